conv3_ctrl: RTL and testbench
=============================

// Module: conv3_ctrl
// PURPOSE
//  Sequencer for the 2x2 dual-channel conv3 datapath. It holds the 8 weights (WA0-3, WB0-3)
//  and streams pixel pairs (A, B) through the datapath, driving sel = 0..3 for the four taps.
//  It sums the four per-tap acc values into one window result and returns it over a
//  valid/ready handshake. It runs num_win windows per start command.
// PARAMETERS
//  DATA_W  13  pixel width, signed (matches conv3 A/B)
//  W_W      8  weight width, signed
//  ACC_W   22  conv3 acc width, signed
//  OUT_W   24  window result width, signed (ACC_W+2; 4-term sum cannot overflow)
//  CNT_W   16  window counter width
// PORTS
//  clk        in   1       clock; all state changes on its rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a run of num_win windows (honoured only in IDLE)
//  num_win    in   CNT_W   windows per run; sampled on accepted start
//  busy       out  1       high in RUN and OUT
//  done       out  1       one-cycle pulse at end of run
//  w_we       in   1       weight write strobe (honoured only in IDLE)
//  w_addr     in   3       0-3 -> WA0-3, 4-7 -> WB0-3
//  w_data     in   W_W     weight value
//  in_valid   in   1       pixel pair valid
//  in_ready   out  1       controller accepts a pair (high only in RUN)
//  in_a       in   DATA_W  channel A pixel
//  in_b       in   DATA_W  channel B pixel
//  out_valid  out  1       window result valid
//  out_ready  in   1       downstream accepts result
//  out_data   out  OUT_W   window result
//  dp_a       out  DATA_W  to conv3 A (= in_a, combinational)
//  dp_b       out  DATA_W  to conv3 B (= in_b, combinational)
//  dp_sel     out  2       to conv3 sel (= tap counter)
//  dp_wa      out  4*W_W   {WA3,WA2,WA1,WA0} to conv3 WA ports
//  dp_wb      out  4*W_W   {WB3,WB2,WB1,WB0} to conv3 WB ports
//  dp_acc     in   ACC_W   from conv3 acc (combinational, same cycle)
// BEHAVIOUR
//  Reset
//   - state=IDLE; tap=0; win_cnt=0; sum=0.
//   - All 8 weights=0.
//   - busy, done, in_ready, out_valid=0; out_data=0.
//   - Reset mid-run aborts the run: no done pulse, partial sum discarded.
//  Weight writes
//   - IDLE && w_we: the addressed weight register updates next edge.
//   - w_we in RUN/OUT is ignored.
//  IDLE
//   - start && num_win!=0: latch num_win; tap=0, sum=0, win_cnt=0; go to RUN.
//   - start && num_win==0: stay IDLE; done=1 on the next cycle.
//  RUN (in_ready=1)
//   - Accept = in_valid && in_ready. No accept: hold all state.
//   - Accept at tap<3: sum += sext(dp_acc); tap++.
//   - Accept at tap==3: out_data <= sum + sext(dp_acc); sum=0; tap=0; go to OUT.
//  OUT (out_valid=1, in_ready=0)
//   - out_data is held stable until out_ready.
//   - On out_ready, if win_cnt==num_win-1: go to IDLE, done=1 next cycle, win_cnt=0.
//   - On out_ready otherwise: win_cnt++, go to RUN.
//   - Latency: out_valid rises the cycle after the 4th accept.
//   - Throughput: max 1 window per 5 cycles.
//  Other rules
//   - start while busy is ignored; num_win changes while busy are ignored.
//   - Sums are signed, two's complement, sign-extended to OUT_W; no saturation needed.
// CONFIGURATION
//  CONV3_CTRL_RELU_EN
//   - Defined: the value latched into out_data is max(result, 0); negative results become 0.
//   - Undefined: the signed result passes unmodified.
//  No other behaviour differs.
// TESTING
//  1. Set all weights=1, num_win=1, start. Send pairs (A,B)=(1,0),(2,0),(3,0),(4,0).
//     -> out_data=10 one cycle after the 4th accept; done pulses after the out handshake.
//  2. WA=2, WB=-1, A=100, B=50 on all 4 taps -> out_data=600.
//     Hold out_ready=0 for 5 cycles -> out_valid and out_data stable; in_ready=0.
//  3. num_win=3 with in_valid gaps -> exactly 3 results in order.
//     done asserts once, only after the 3rd out handshake.
//  4. Write w_addr=4, w_data=7 while busy -> WB0 unchanged.
//     Repeat the write in IDLE -> dp_wb[7:0]=7. start during RUN has no effect.
//  5. Assert rst after 2 accepts -> IDLE; all outputs 0; weights 0; no done pulse.
//     start with num_win=0 -> done pulses 1 cycle later; busy stays 0.
//  6. WA=-1, A=10 per tap -> result -40.
//     Without CONV3_CTRL_RELU_EN: out_data=-40. With it defined: out_data=0.

Source files
------------

// File: rtl/conv3_ctrl_if.sv
// conv3_ctrl_if: pixel-pair input stream and window-result output stream
interface conv3_ctrl_if #(
    parameter int DATA_W = 13,
    parameter int OUT_W  = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    // Producer of pixels and consumer of results (testbench / upstream logic)
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The controller side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv3_ctrl.sv
// conv3_ctrl: sequencer for the 2x2 dual-channel conv3 datapath (optional ReLU via CONV3_CTRL_RELU_EN)
module conv3_ctrl #(
    parameter int DATA_W = 13,
    parameter int W_W    = 8,
    parameter int ACC_W  = 22,
    parameter int OUT_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_win,
    output logic               busy,
    output logic               done,
    input  logic               w_we,
    input  logic [2:0]         w_addr,
    input  logic [W_W-1:0]     w_data,
    conv3_ctrl_if.slave        stream,
    output logic [DATA_W-1:0]  dp_a,
    output logic [DATA_W-1:0]  dp_b,
    output logic [1:0]         dp_sel,
    output logic [4*W_W-1:0]   dp_wa,
    output logic [4*W_W-1:0]   dp_wb,
    input  logic [ACC_W-1:0]   dp_acc
);
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                    state, state_nx;
    logic [1:0]                tap;
    logic [CNT_W-1:0]          win_cnt, num_lat;
    logic signed [OUT_W-1:0]   sum, acc_ext, result, result_out, out_q;
    logic                      done_q;
    logic [W_W-1:0]            wa [4];
    logic [W_W-1:0]            wb [4];
    logic                      start_ok, start_zero, accept, out_fire, last_win;

    assign start_ok   = state == IDLE && start && num_win != '0;
    assign start_zero = state == IDLE && start && num_win == '0;
    assign accept     = state == RUN && stream.in_valid;
    assign out_fire   = state == OUT && stream.out_ready;
    assign last_win   = win_cnt == num_lat - CNT_W'(1);

    assign acc_ext = {{(OUT_W-ACC_W){dp_acc[ACC_W-1]}}, dp_acc};
    assign result  = sum + acc_ext;
`ifdef CONV3_CTRL_RELU_EN
    assign result_out = result[OUT_W-1] ? '0 : result;
`else
    assign result_out = result;
`endif

    assign busy             = state != IDLE;
    assign done             = done_q;
    assign stream.in_ready  = state == RUN;
    assign stream.out_valid = state == OUT;
    assign stream.out_data  = out_q;
    assign dp_a             = stream.in_a;
    assign dp_b             = stream.in_b;
    assign dp_sel           = tap;
    assign dp_wa            = {wa[3], wa[2], wa[1], wa[0]};
    assign dp_wb            = {wb[3], wb[2], wb[1], wb[0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: start launches a run, 4th accept emits, out handshake loops or ends
    always_comb begin
        state_nx = state;
        if (start_ok) state_nx = RUN;
        if (accept && tap == 2'd3) state_nx = OUT;
        if (out_fire) state_nx = last_win ? IDLE : RUN;
    end

    // Tap/window counters, running sum, result register and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            tap     <= '0;
            win_cnt <= '0;
            num_lat <= '0;
            sum     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= start_zero || (out_fire && last_win);
            if (start_ok) begin
                num_lat <= num_win;
                tap     <= '0;
                sum     <= '0;
                win_cnt <= '0;
            end
            if (accept) begin
                tap <= tap + 2'd1;
                sum <= tap == 2'd3 ? '0 : result;
                if (tap == 2'd3) out_q <= result_out;
            end
            if (out_fire) win_cnt <= last_win ? '0 : win_cnt + CNT_W'(1);
        end
    end

    // Weight bank: writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wa[i] <= '0;
                wb[i] <= '0;
            end
        end else if (state == IDLE && w_we) begin
            if (w_addr[2]) wb[w_addr[1:0]] <= w_data;
            else           wa[w_addr[1:0]] <= w_data;
        end
    end
endmodule

// File: tb/tb_conv3_ctrl.sv
// tb_conv3_ctrl: directed scoreboard bench for conv3_ctrl with a behavioural conv3 datapath
module tb_conv3_ctrl;
    localparam int DATA_W = 13;
    localparam int W_W    = 8;
    localparam int ACC_W  = 22;
    localparam int OUT_W  = 24;
    localparam int CNT_W  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_win = '0;
    logic               busy, done;
    logic               w_we = 1'b0;
    logic [2:0]         w_addr = '0;
    logic [W_W-1:0]     w_data = '0;
    logic [DATA_W-1:0]  dp_a, dp_b;
    logic [1:0]         dp_sel;
    logic [4*W_W-1:0]   dp_wa, dp_wb;
    logic [ACC_W-1:0]   dp_acc;
    logic signed [W_W-1:0] wsa, wsb;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic signed [W_W-1:0] wa_m [4];
    logic signed [W_W-1:0] wb_m [4];
    logic signed [63:0] q [$];

    conv3_ctrl_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    conv3_ctrl #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_win(num_win), .busy(busy), .done(done),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .stream(bus),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_wa(dp_wa), .dp_wb(dp_wb), .dp_acc(dp_acc)
    );

    always #5 clk = ~clk;

    // Behavioural conv3: acc = A*WA[sel] + B*WB[sel], combinational
    assign wsa    = dp_wa[dp_sel*W_W +: W_W];
    assign wsb    = dp_wb[dp_sel*W_W +: W_W];
    assign dp_acc = ACC_W'($signed(dp_a)) * ACC_W'(wsa) + ACC_W'($signed(dp_b)) * ACC_W'(wsb);

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_w(input logic [2:0] addr, input logic [W_W-1:0] data);
        w_we = 1'b1;
        w_addr = addr;
        w_data = data;
        tick;
        w_we = 1'b0;
    endtask

    task automatic set_weights(input logic signed [W_W-1:0] a, input logic signed [W_W-1:0] b);
        for (int i = 0; i < 4; i++) begin
            write_w(3'(i), a);
            write_w(3'(i + 4), b);
            wa_m[i] = a;
            wb_m[i] = b;
        end
    endtask

    task automatic start_run(input int n);
        num_win = CNT_W'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b, input int gap);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) break;
            tick;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $error("FAIL in_ready_wait: got 0, expected 1 within 50 cycles");
        end
        tick;
        bus.in_valid = 1'b0;
        repeat (gap) tick;
    endtask

    function automatic logic signed [63:0] exp_win(input logic signed [DATA_W-1:0] a [4],
                                                   input logic signed [DATA_W-1:0] b [4]);
        logic signed [63:0] s;
        s = 0;
        for (int i = 0; i < 4; i++) s += 64'(a[i]) * 64'(wa_m[i]) + 64'(b[i]) * 64'(wb_m[i]);
`ifdef CONV3_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic send_window(input logic signed [DATA_W-1:0] a [4],
                               input logic signed [DATA_W-1:0] b [4], input int gap);
        q.push_back(exp_win(a, b));
        for (int i = 0; i < 4; i++) send_pair(a[i], b[i], i < 3 ? gap : 0);
    endtask

    task automatic collect(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid) break;
            tick;
        end
        if (!bus.out_valid || q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_wait: got out_valid=%0b queue=%0d, expected a result", tag, bus.out_valid, q.size());
        end else begin
            check(tag, $signed(bus.out_data), q.pop_front());
            bus.out_ready = 1'b1;
            tick;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        logic signed [DATA_W-1:0] pa [4];
        logic signed [DATA_W-1:0] pb [4];
        int d0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wa_m[i] = '0;
            wb_m[i] = '0;
        end
        repeat (2) tick;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", $signed(bus.out_data), 0);
        check("rst_dp_wa", dp_wa, 0);
        check("rst_dp_wb", dp_wb, 0);

        // 1: unit weights, ramp on A
        set_weights(8'sd1, 8'sd1);
        start_run(1);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            pa[i] = 13'(i + 1);
            pb[i] = '0;
        end
        send_window(pa, pb, 0);
        check("t1_latency", bus.out_valid, 1);
        check("t1_value", $signed(bus.out_data), 10);
        collect("t1_out");
        check("t1_done", done, 1);
        check("t1_out_valid_low", bus.out_valid, 0);
        tick;
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);

        // 2: WA=2, WB=-1, backpressure
        set_weights(8'sd2, -8'sd1);
        start_run(1);
        for (int i = 0; i < 4; i++) begin
            pa[i] = 13'sd100;
            pb[i] = 13'sd50;
        end
        send_window(pa, pb, 0);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", bus.out_valid, 1);
            check("t2_hold_data", $signed(bus.out_data), 600);
            check("t2_hold_in_ready", bus.in_ready, 0);
            tick;
        end
        collect("t2_out");
        check("t2_done", done, 1);
        tick;

        // 3: three windows with input gaps
        d0 = done_cnt;
        start_run(3);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                pa[i] = 13'(w * 50 + i * 7 - 20);
                pb[i] = 13'(i - w * 3);
            end
            send_window(pa, pb, 1);
            collect("t3_out");
            if (w < 2) begin
                check("t3_no_early_done", done, 0);
                check("t3_busy", busy, 1);
            end
        end
        check("t3_done", done, 1);
        repeat (3) tick;
        check("t3_done_once", done_cnt, d0 + 1);

        // 4: weight write and start ignored while busy
        start_run(1);
        write_w(3'd4, 8'd7);
        check("t4_wb0_locked", $signed(dp_wb[7:0]), wb_m[0]);
        num_win = 16'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("t4_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            pa[i] = 13'sd3;
            pb[i] = 13'sd4;
        end
        send_window(pa, pb, 0);
        collect("t4_out");
        check("t4_single_window_done", done, 1);
        tick;
        check("t4_idle", busy, 0);
        write_w(3'd4, 8'd7);
        wb_m[0] = 8'sd7;
        check("t4_wb0_written", $signed(dp_wb[7:0]), 7);

        // 5: reset mid-run, then zero-window start
        d0 = done_cnt;
        start_run(2);
        send_pair(13'sd1, 13'sd1, 0);
        send_pair(13'sd2, 13'sd2, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wa_m[i] = '0;
            wb_m[i] = '0;
        end
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_in_ready", bus.in_ready, 0);
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_out_data", $signed(bus.out_data), 0);
        check("t5_dp_sel", dp_sel, 0);
        check("t5_dp_wa", dp_wa, 0);
        check("t5_dp_wb", dp_wb, 0);
        repeat (3) tick;
        check("t5_no_done", done_cnt, d0);
        start_run(0);
        check("t5_zero_done", done, 1);
        check("t5_zero_busy", busy, 0);
        tick;
        check("t5_zero_done_pulse", done, 0);
        check("t5_zero_busy_after", busy, 0);

        // 6: negative result, ReLU dependent
        set_weights(-8'sd1, 8'sd0);
        start_run(1);
        for (int i = 0; i < 4; i++) begin
            pa[i] = 13'sd10;
            pb[i] = 13'sd5;
        end
        send_window(pa, pb, 0);
`ifdef CONV3_CTRL_RELU_EN
        check("t6_relu", $signed(bus.out_data), 0);
`else
        check("t6_negative", $signed(bus.out_data), -40);
`endif
        collect("t6_out");
        check("t6_done", done, 1);
        tick;
        check("t6_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
